// File: rtl/window_writer.sv
// window_writer: applies the symmetric sine window to one IMDCT frame and streams it
// into the 4-slot window/overlap memory, gated by slot credits from the overlap stage.
module window_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sampleIn,
  input  logic        sampleValid,
  output logic        sampleReady,
  output logic [8:0]  coefAddress,
  input  logic [15:0] coefData,
  output logic [11:0] memAddress,
  output logic [15:0] memData,
  output logic        memWrite,
  input  logic        frameRelease,
  output logic        frameDone,
  output logic [1:0]  slotIndex,
  output logic        creditError
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [9:0] word_idx, s1_word;
  logic [15:0] s1_sample, win;
  logic [1:0] s1_slot, free_slots, free_nx;
  logic s1_valid, flush_cnt, accept, err_nx;
  logic signed [32:0] prod;
  assign accept = (state == RUN) && sampleValid;
  assign sampleReady = state == RUN;
  // coefficient is unsigned Q0.16, so widen it with a zero sign bit before the signed multiply
  assign prod = $signed(s1_sample) * $signed({1'b0, coefData});
  assign win = 16'((prod + 33'sd32768) >>> 16);
  always_comb begin
    state_nx = (state == IDLE) ? ((free_slots != 2'd0) ? RUN : IDLE) :
               (state == RUN) ? ((accept && word_idx == 10'd1023) ? FLUSH : RUN) :
               (flush_cnt ? IDLE : FLUSH);
    free_nx = (frameRelease && !frameDone) ? ((free_slots == 2'd3) ? free_slots : free_slots + 2'd1) :
              (frameDone && !frameRelease) ? free_slots - 2'd1 : free_slots;
    err_nx = creditError | (frameRelease && !frameDone && free_slots == 2'd3);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      flush_cnt <= 1'b0;
      word_idx <= '0;
      slotIndex <= '0;
      free_slots <= 2'd3;
      creditError <= 1'b0;
      s1_sample <= '0;
      s1_word <= '0;
      s1_slot <= '0;
      s1_valid <= 1'b0;
      coefAddress <= '0;
      memData <= '0;
      memAddress <= '0;
      memWrite <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state <= state_nx;
      flush_cnt <= (state == FLUSH) && !flush_cnt;
      free_slots <= free_nx;
      creditError <= err_nx;
      s1_valid <= accept;
      if (accept) begin
        word_idx <= word_idx + 10'd1;
        s1_sample <= sampleIn;
        s1_word <= word_idx;
        s1_slot <= slotIndex;
        coefAddress <= word_idx[9] ? ~word_idx[8:0] : word_idx[8:0];
      end
      memWrite <= s1_valid;
      frameDone <= s1_valid && s1_word == 10'd1023;
      if (s1_valid) begin
        memData <= win;
        memAddress <= {s1_slot, s1_word};
      end
      if (frameDone) slotIndex <= slotIndex + 2'd1;
    end
  end
endmodule

// File: tb/tb_window_writer.sv
// tb_window_writer: directed scenarios for window_writer with a cycle-level write monitor.
module tb_window_writer;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] sampleIn = '0, coefData = '0;
  logic sampleValid = 1'b0, frameRelease = 1'b0;
  logic sampleReady, memWrite, frameDone, creditError;
  logic [8:0] coefAddress;
  logic [11:0] memAddress;
  logic [15:0] memData;
  logic [1:0] slotIndex;
  int errors = 0, checks = 0;
  int wr_err = 0, done_err = 0, addr_err = 0, data_err = 0, n_wr = 0, n_fd = 0;
  logic [9:0] exp_word = '0;
  logic [1:0] exp_slot = '0;
  logic [15:0] exp_data = '0, last_data = '0;
  logic [11:0] last_addr = '0;
  bit chk_data = 1'b0;
  logic a1 = 1'b0, a2 = 1'b0;

  always #5 clk = ~clk;

  window_writer dut (
    .clk(clk), .rst(rst), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .coefAddress(coefAddress), .coefData(coefData),
    .memAddress(memAddress), .memData(memData), .memWrite(memWrite),
    .frameRelease(frameRelease), .frameDone(frameDone), .slotIndex(slotIndex),
    .creditError(creditError)
  );

  // an accept on edge N must show up as memWrite after edge N+1
  always @(posedge clk or negedge rst)
    if (!rst) begin
      a1 <= 1'b0;
      a2 <= 1'b0;
    end else begin
      a1 <= sampleReady && sampleValid;
      a2 <= a1;
    end

  always @(negedge clk)
    if (rst) begin
      if (memWrite !== a2) wr_err++;
      if (frameDone !== (a2 && exp_word == 10'd1023)) done_err++;
      if (frameDone) n_fd++;
      if (memWrite) begin
        if (memAddress !== {exp_slot, exp_word}) addr_err++;
        if (chk_data && memData !== exp_data) data_err++;
        last_data = memData;
        last_addr = memAddress;
        n_wr++;
        if (exp_word == 10'd1023) begin
          exp_word = '0;
          exp_slot = exp_slot + 2'd1;
        end else exp_word = exp_word + 10'd1;
      end
    end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [15:0] s, input bit bubbles);
    int acc = 0, cyc = 0;
    while (acc < n && cyc < 5000) begin
      @(posedge clk); #1;
      sampleIn = s;
      sampleValid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sampleReady && sampleValid) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    sampleValid = 1'b0;
    checks++;
    if (acc != n) begin errors++; $display("FAIL send_accepts: got %0d want %0d", acc, n); end
  endtask

  task automatic pulse_release();
    frameRelease = 1'b1;
    @(posedge clk); #1;
    frameRelease = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    sampleValid = 1'b0;
    frameRelease = 1'b0;
    #2 rst = 1'b1;
    exp_word = '0;
    exp_slot = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({sampleReady, coefAddress, memAddress, memData, memWrite, frameDone, slotIndex, creditError} !== 43'd0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b coef=%h addr=%h data=%h wr=%b done=%b slot=%0d err=%b want all 0",
        sampleReady, coefAddress, memAddress, memData, memWrite, frameDone, slotIndex, creditError);
    end
    checks++;
    if (dut.free_slots !== 2'd3) begin errors++; $display("FAIL reset_free: got %0d want 3", dut.free_slots); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sampleReady !== 1'b1) begin errors++; $display("FAIL reset_to_run: ready=%b want 1", sampleReady); end
  endtask

  task automatic test_full_frame();
    coefData = 16'hFFFF;
    exp_data = 16'h7FFF;
    chk_data = 1'b1;
    send(1024, 16'h7FFF, 1'b0);
    idle(4);
    checks++;
    if (n_wr != 1024) begin errors++; $display("FAIL full_writes: got %0d want 1024", n_wr); end
    checks++;
    if (data_err != 0) begin errors++; $display("FAIL full_data: %0d bad words want 0", data_err); end
    checks++;
    if (addr_err != 0) begin errors++; $display("FAIL full_addr: %0d bad addresses want 0", addr_err); end
    checks++;
    if (done_err != 0) begin errors++; $display("FAIL full_done_timing: %0d bad cycles want 0", done_err); end
    checks++;
    if (n_fd != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", n_fd); end
    checks++;
    if (last_addr !== 12'h3FF) begin errors++; $display("FAIL full_last_addr: got %h want 3ff", last_addr); end
    checks++;
    if (slotIndex !== 2'd1) begin errors++; $display("FAIL full_slot: got %0d want 1", slotIndex); end
    checks++;
    if (dut.free_slots !== 2'd2) begin errors++; $display("FAIL full_free: got %0d want 2", dut.free_slots); end
  endtask

  task automatic test_rounding();
    chk_data = 1'b0;
    coefData = 16'h8000;
    send(1, 16'h8000, 1'b0);
    checks++;
    if (coefAddress !== 9'd0) begin errors++; $display("FAIL coef_w0: got %0d want 0", coefAddress); end
    idle(3);
    checks++;
    if (last_data !== 16'hC000) begin errors++; $display("FAIL round_neg: got %h want c000", last_data); end
    send(1, 16'h0001, 1'b0);
    idle(3);
    checks++;
    if (last_data !== 16'h0001) begin errors++; $display("FAIL round_pos: got %h want 0001", last_data); end
  endtask

  task automatic test_coef_fold();
    send(510, 16'h1234, 1'b0);
    checks++;
    if (coefAddress !== 9'd511) begin errors++; $display("FAIL coef_w511: got %0d want 511", coefAddress); end
    send(1, 16'h1234, 1'b0);
    checks++;
    if (coefAddress !== 9'd511) begin errors++; $display("FAIL coef_w512: got %0d want 511", coefAddress); end
    send(511, 16'h1234, 1'b0);
    checks++;
    if (coefAddress !== 9'd0) begin errors++; $display("FAIL coef_w1023: got %0d want 0", coefAddress); end
    idle(4);
    checks++;
    if (n_fd != 2 || slotIndex !== 2'd2) begin
      errors++; $display("FAIL fold_frame: done=%0d slot=%0d want 2 and 2", n_fd, slotIndex);
    end
  endtask

  task automatic test_credit_stall();
    int base, viol, k;
    do_reset();
    base = n_fd;
    coefData = 16'hFFFF;
    exp_data = 16'h7FFF;
    chk_data = 1'b1;
    repeat (3) send(1024, 16'h7FFF, 1'b0);
    idle(4);
    checks++;
    if (n_fd != base + 3 || slotIndex !== 2'd3 || dut.free_slots !== 2'd0) begin
      errors++; $display("FAIL stall_state: done=%0d slot=%0d free=%0d want %0d 3 0", n_fd - base, slotIndex, dut.free_slots, 3);
    end
    viol = 0;
    sampleValid = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (sampleReady || memWrite) viol++;
    end
    sampleValid = 1'b0;
    checks++;
    if (viol != 0) begin errors++; $display("FAIL stall_hold: %0d active cycles want 0", viol); end
    pulse_release();
    k = 0;
    while (!sampleReady && k < 4) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sampleReady !== 1'b1 || k > 1) begin errors++; $display("FAIL stall_resume: ready=%b extra=%0d want 1 within 1", sampleReady, k); end
    send(1024, 16'h7FFF, 1'b0);
    idle(4);
    checks++;
    if (last_addr !== 12'hFFF || slotIndex !== 2'd0) begin
      errors++; $display("FAIL slot3_frame: last=%h slot=%0d want fff 0", last_addr, slotIndex);
    end
    pulse_release();
    send(1024, 16'h7FFF, 1'b0);
    idle(4);
    checks++;
    if (last_addr !== 12'h3FF || slotIndex !== 2'd1) begin
      errors++; $display("FAIL wrap_frame: last=%h slot=%0d want 3ff 1", last_addr, slotIndex);
    end
    checks++;
    if (addr_err != 0 || data_err != 0) begin errors++; $display("FAIL stall_writes: addr_err=%0d data_err=%0d want 0", addr_err, data_err); end
  endtask

  task automatic test_release_with_done();
    pulse_release();
    send(1024, 16'h7FFF, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (frameDone !== 1'b1) begin errors++; $display("FAIL coinc_done: got %b want 1", frameDone); end
    pulse_release();
    idle(2);
    checks++;
    if (dut.free_slots !== 2'd1 || creditError !== 1'b0) begin
      errors++; $display("FAIL coinc_free: free=%0d err=%b want 1 0", dut.free_slots, creditError);
    end
  endtask

  task automatic test_credit_error();
    do_reset();
    pulse_release();
    checks++;
    if (creditError !== 1'b1 || dut.free_slots !== 2'd3) begin
      errors++; $display("FAIL credit_err: err=%b free=%0d want 1 3", creditError, dut.free_slots);
    end
    idle(5);
    checks++;
    if (creditError !== 1'b1) begin errors++; $display("FAIL credit_sticky: got %b want 1", creditError); end
  endtask

  task automatic test_bubble_reset();
    int base, wbase;
    do_reset();
    base = n_fd;
    send(300, 16'h7FFF, 1'b1);
    rst = 1'b0;
    #1;
    checks++;
    if ({sampleReady, coefAddress, memAddress, memData, memWrite, frameDone, slotIndex, creditError} !== 43'd0) begin
      errors++; $display("FAIL async_clear: ready=%b coef=%h addr=%h data=%h wr=%b done=%b slot=%0d err=%b want all 0",
        sampleReady, coefAddress, memAddress, memData, memWrite, frameDone, slotIndex, creditError);
    end
    checks++;
    if (wr_err != 0) begin errors++; $display("FAIL bubble_writes: %0d mismatched cycles want 0", wr_err); end
    #1 rst = 1'b1;
    exp_word = '0;
    exp_slot = '0;
    wbase = n_wr;
    @(posedge clk); #1;
    send(1024, 16'h7FFF, 1'b0);
    idle(4);
    checks++;
    if (n_fd != base + 1) begin errors++; $display("FAIL abort_no_done: got %0d frames want 1", n_fd - base); end
    checks++;
    if (n_wr - wbase != 1024 || last_addr !== 12'h3FF || addr_err != 0) begin
      errors++; $display("FAIL restart_frame: writes=%0d last=%h addr_err=%0d want 1024 3ff 0", n_wr - wbase, last_addr, addr_err);
    end
    checks++;
    if (done_err != 0 || data_err != 0) begin errors++; $display("FAIL final_monitor: done_err=%0d data_err=%0d want 0", done_err, data_err); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_rounding();
    test_coef_fold();
    test_credit_stall();
    test_release_with_done();
    test_credit_error();
    test_bubble_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
